// File: rtl/program_loader.sv
// Serial program image loader: length byte, payload words, XOR checksum.
// Fills a 256 x 64-bit image and reports done/error to the core.
module program_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [0:7]         byte_data,
  output logic               byte_ready,
  output logic [0:255][0:63] program_mem,
  output logic               loading,
  output logic               done,
  output logic               error,
  output logic [0:8]         words_loaded
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic          busy;
  logic [0:63]   asm_q;
  logic [0:7]    csum;
  logic [2:0]    bcnt;
  logic [0:8]    n_words;
  logic [CW-1:0] idle_cnt;
  logic          accept;
  logic [0:63]   word;
  logic [0:8]    wl_next;

  assign accept     = byte_valid & busy;
  assign byte_ready = busy;
  assign loading    = busy;
  assign word       = {asm_q[8:63], byte_data};
  assign wl_next    = words_loaded + 9'd1;

  // Load sequencer: state, image writes, checksum and idle watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      program_mem  <= '0;
      asm_q        <= '0;
      csum         <= '0;
      bcnt         <= '0;
      n_words      <= '0;
      idle_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            busy         <= 1'b1;
            program_mem  <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            csum         <= '0;
            idle_cnt     <= '0;
            asm_q        <= '0;
            bcnt         <= '0;
          end
        end
        S_LEN, S_DATA, S_CHECK: begin
          if (accept) begin
            idle_cnt <= '0;
            if (state == S_LEN) begin
              n_words <= (byte_data == 8'd0) ?
                         9'd256 : {1'b0, byte_data};
              state   <= S_DATA;
            end else if (state == S_DATA) begin
              asm_q <= word;
              csum  <= csum ^ byte_data;
              bcnt  <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                program_mem[words_loaded[1:8]] <= word;
                words_loaded <= wl_next;
                if (wl_next == n_words)
                  state <= S_CHECK;
              end
            end else begin
              busy <= 1'b0;
              if (byte_data == csum) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_ERR;
                error <= 1'b1;
              end
            end
          end else if (idle_cnt == IDLE_MAX) begin
            state <= S_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a short watchdog.
// Covers good/bad loads, full image, gaps, timeout and resets.
module tb_program_loader;

  logic               clk;
  logic               rst;
  logic               start;
  logic               byte_valid;
  logic [0:7]         byte_data;
  logic               byte_ready;
  logic [0:255][0:63] mem;
  logic               loading;
  logic               done;
  logic               error;
  logic [0:8]         words_loaded;

  int total;
  int passed;

  program_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .program_mem  (mem),
    .loading      (loading),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 7; i >= 0; i--)
      send_byte(w[i*8 +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(byte_ready), 64'd0);
    chk("rst_loading", 64'(loading), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words", 64'(words_loaded), 64'd0);
    chk("rst_mem", 64'(mem == '0), 64'd1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", 64'(loading), 64'd0);

    // single-word good load
    pulse_start();
    chk("a_loading", 64'(loading), 64'd1);
    chk("a_ready", 64'(byte_ready), 64'd1);
    send_byte(8'h01);
    send_word(64'h1122334455667788);
    chk("a_in_check", 64'(loading), 64'd1);
    send_byte(8'h88);
    chk("a_done", 64'(done), 64'd1);
    chk("a_error", 64'(error), 64'd0);
    chk("a_loading_off", 64'(loading), 64'd0);
    chk("a_words", 64'(words_loaded), 64'd1);
    chk("a_mem0", mem[0], 64'h1122334455667788);
    chk("a_mem1", mem[1], 64'd0);

    // bad checksum
    pulse_start();
    chk("b_cleared_done", 64'(done), 64'd0);
    send_byte(8'h01);
    send_word(64'h1122334455667788);
    send_byte(8'h00);
    chk("b_error", 64'(error), 64'd1);
    chk("b_done", 64'(done), 64'd0);
    chk("b_mem0", mem[0], 64'h1122334455667788);
    repeat (5) @(negedge clk);
    chk("b_error_hold", 64'(error), 64'd1);
    chk("b_ready_off", 64'(byte_ready), 64'd0);

    // start asserted in DATA has no effect
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    start = 1'b1;
    send_byte(8'hA4);
    send_byte(8'hA5);
    start = 1'b0;
    send_byte(8'hA6);
    send_byte(8'hA7);
    send_byte(8'hA8);
    send_byte(8'h08);
    chk("c_done", 64'(done), 64'd1);
    chk("c_words", 64'(words_loaded), 64'd1);
    chk("c_mem0", mem[0], 64'hA1A2A3A4A5A6A7A8);

    // 15-cycle gaps survive, 16-cycle gap times out
    pulse_start();
    repeat (15) @(negedge clk);
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      repeat (15) @(negedge clk);
      send_byte(8'hC1 + 8'(i));
    end
    chk("t_words", 64'(words_loaded), 64'd1);
    chk("t_mem0", mem[0], 64'hC1C2C3C4C5C6C7C8);
    repeat (15) @(negedge clk);
    chk("t_15_error", 64'(error), 64'd0);
    chk("t_15_loading", 64'(loading), 64'd1);
    @(negedge clk);
    chk("t_16_error", 64'(error), 64'd1);
    chk("t_16_loading", 64'(loading), 64'd0);
    chk("t_16_done", 64'(done), 64'd0);

    // full 256-word load
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++)
      send_word({8{8'(i)}});
    chk("f_in_check", 64'(loading), 64'd1);
    send_byte(8'h00);
    chk("f_done", 64'(done), 64'd1);
    chk("f_words", 64'(words_loaded), 64'd256);
    chk("f_mem255", mem[255], 64'hFFFFFFFFFFFFFFFF);
    chk("f_mem128", mem[128], 64'h8080808080808080);
    chk("f_mem0", mem[0], 64'd0);

    // reset in the middle of a word
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    rst = 1'b0;
    #1;
    chk("r_ready", 64'(byte_ready), 64'd0);
    chk("r_loading", 64'(loading), 64'd0);
    chk("r_words", 64'(words_loaded), 64'd0);
    chk("r_done", 64'(done), 64'd0);
    chk("r_error", 64'(error), 64'd0);
    chk("r_mem", 64'(mem == '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("r_idle", 64'(loading), 64'd0);
    pulse_start();
    send_byte(8'h01);
    send_word(64'hD1D2D3D4D5D6D7D8);
    send_byte(8'h08);
    chk("r_new_done", 64'(done), 64'd1);
    chk("r_new_mem0", mem[0], 64'hD1D2D3D4D5D6D7D8);
    chk("r_new_words", 64'(words_loaded), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
